// File: rtl/mc_control.sv
// Multi-cycle processor control FSM with memory handshake, wait-timeout and branch status.
module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       link,
    output logic       instr_done,
    output logic       mem_err,
    output logic       illegal,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [2:0] status,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_RESOLVE   = 4'd9;

    localparam logic [3:0] C_R    = 4'd0;
    localparam logic [3:0] C_LW   = 4'd1;
    localparam logic [3:0] C_SW   = 4'd2;
    localparam logic [3:0] C_BEQ  = 4'd3;
    localparam logic [3:0] C_BMN  = 4'd4;
    localparam logic [3:0] C_BZ   = 4'd5;
    localparam logic [3:0] C_JALM = 4'd6;
    localparam logic [3:0] C_BRZ  = 4'd7;
    localparam logic [3:0] C_JMOR = 4'd8;
    localparam logic [3:0] C_ILL  = 4'd9;

    logic [3:0] r_state, w_next;
    logic [3:0] r_cls, w_cls;
    logic [2:0] r_status, w_status;
    logic [7:0] r_cnt;
    logic       w_timeout, w_wait;
    logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_link, w_instr_done;
    logic       w_mem_err, w_illegal;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

    // Instruction class and branch status decode from the instruction register fields.
    always_comb begin
        w_cls    = C_ILL;
        w_status = 3'b000;
        unique case (op)
            6'd0: begin
                if (funct == 6'd20) begin
                    w_cls    = C_BRZ;
                    w_status = 3'b010;
                end else if (funct == 6'd37) begin
                    w_cls    = C_JMOR;
                    w_status = 3'b100;
                end else begin
                    w_cls    = C_R;
                end
            end
            6'd35: w_cls = C_LW;
            6'd43: w_cls = C_SW;
            6'd4:  begin w_cls = C_BEQ;  w_status = 3'b111; end
            6'd21: begin w_cls = C_BMN;  w_status = 3'b001; end
            6'd24: begin w_cls = C_BZ;   w_status = 3'b011; end
            6'd19: begin w_cls = C_JALM; w_status = 3'b101; end
            default: w_cls = C_ILL;
        endcase
    end

    assign w_timeout = (r_cnt >= 8'(MEM_TIMEOUT)) && !mem_ready;
    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE))
                       && !mem_ready && !w_timeout;

    // Next-state and Moore outputs; handshake strobes qualified by mem_ready.
    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_link          = 1'b0;
        w_instr_done    = 1'b0;
        w_mem_err       = 1'b0;
        w_illegal       = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_next      = S_FETCH;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_mem_err    = 1'b1;
                    w_instr_done = 1'b1;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (w_cls)
                    C_LW, C_SW, C_BMN, C_JMOR, C_JALM: w_next = S_MEM_ADDR;
                    C_BEQ, C_BZ, C_BRZ:                w_next = S_BRANCH;
                    C_R:                               w_next = S_EXEC_R;
                    default: begin
                        w_illegal    = 1'b1;
                        w_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = (r_cls == C_JMOR) ? 2'b00 : 2'b10;
                w_next      = (r_cls == C_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                w_next     = S_MEM_READ;
                if (mem_ready) begin
                    w_next = (r_cls == C_LW) ? S_MEM_WB : S_RESOLVE;
                end else if (w_timeout) begin
                    w_mem_err    = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_MEM_WRITE;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_timeout) begin
                    w_mem_write  = 1'b0;
                    w_mem_err    = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
            end
            S_RESOLVE: begin
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b10;
                w_instr_done    = 1'b1;
                w_link          = (r_cls == C_JALM);
                w_reg_write     = (r_cls == C_JALM);
            end
            default: w_next = S_FETCH;
        endcase
    end

    // State, latched class/status and saturating memory wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_cls    <= C_R;
            r_status <= 3'b000;
            r_cnt    <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls    <= w_cls;
                r_status <= w_status;
            end else if (w_next == S_FETCH) begin
                r_status <= 3'b000;
            end
            if (w_wait) begin
                r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // Outputs forced low while reset is held so no strobe escapes mid-instruction.
    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign iord          = w_iord          & ~reset;
    assign mem_read      = w_mem_read      & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_dst       = w_reg_dst       & ~reset;
    assign mem_to_reg    = w_mem_to_reg    & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign alu_src_a     = w_alu_src_a     & ~reset;
    assign link          = w_link          & ~reset;
    assign instr_done    = w_instr_done    & ~reset;
    assign mem_err       = w_mem_err       & ~reset;
    assign illegal       = w_illegal       & ~reset;
    assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
    assign alu_op        = reset ? 2'b00 : w_alu_op;
    assign pc_source     = reset ? 2'b00 : w_pc_source;
    assign status        = r_status;
    assign state         = r_state;

endmodule
